// File: rtl/rop3_scheduler_if.sv
// Job, engine and response signals between the host-side requesters, the
// scheduler and one ROP3 engine. The scheduler uses the slave modport.
interface rop3_scheduler_if #(parameter int N = 8);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_p;
  logic [N-1:0] req0_s;
  logic [N-1:0] req0_d;
  logic [7:0]   req0_mode;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_p;
  logic [N-1:0] req1_s;
  logic [N-1:0] req1_d;
  logic [7:0]   req1_mode;
  logic         eng_start;
  logic [N-1:0] eng_bitmap;
  logic [7:0]   eng_mode;
  logic         eng_valid;
  logic [N-1:0] eng_result;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [N-1:0] resp_result;
  logic         resp_err;

  modport master (
    output req0_valid, req0_p, req0_s, req0_d, req0_mode,
    input  req0_ready,
    output req1_valid, req1_p, req1_s, req1_d, req1_mode,
    input  req1_ready,
    input  eng_start, eng_bitmap, eng_mode,
    output eng_valid, eng_result,
    input  resp_valid, resp_id, resp_result, resp_err,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_p, req0_s, req0_d, req0_mode,
    output req0_ready,
    input  req1_valid, req1_p, req1_s, req1_d, req1_mode,
    output req1_ready,
    output eng_start, eng_bitmap, eng_mode,
    input  eng_valid, eng_result,
    output resp_valid, resp_id, resp_result, resp_err,
    input  resp_ready
  );
endinterface

// File: rtl/rop3_scheduler.sv
// Round-robin scheduler that serialises two requesters' ROP3 jobs onto one
// engine and returns the tagged result, with a timeout guard in WAIT.
//   state  | meaning
//   IDLE   | no job; ready offered to the round-robin winner
//   SEND_P | P beat to engine with eng_start
//   SEND_S | S beat
//   SEND_D | D beat; timeout counter cleared
//   WAIT   | D held, waiting for eng_valid or timeout
//   RESP   | response held until resp_ready
module rop3_scheduler #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input logic             clk,
  input logic             arst,
  rop3_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEND_P, SEND_S, SEND_D, WAIT, RESP} state_t;

  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  state_t        state, next;
  logic [N-1:0]  job_p, job_s, job_d, res;
  logic [7:0]    job_mode;
  logic          job_id, rr_last, err;
  logic [CW-1:0] cnt;
  logic          gnt_id, accept, timeout;
  logic [N-1:0]  bitmap;

  always_comb begin
    gnt_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) gnt_id = ~rr_last;
    else if (bus.req1_valid)              gnt_id = 1'b1;
  end

  assign accept  = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign timeout = (cnt == TC);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (accept) next = SEND_P;
      SEND_P: next = SEND_S;
      SEND_S: next = SEND_D;
      SEND_D: next = WAIT;
      WAIT:   if (bus.eng_valid || timeout) next = RESP;
      RESP:   if (bus.resp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      job_p    <= '0;
      job_s    <= '0;
      job_d    <= '0;
      job_mode <= '0;
      job_id   <= 1'b0;
      rr_last  <= 1'b1;
      cnt      <= '0;
      res      <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          job_p    <= gnt_id ? bus.req1_p    : bus.req0_p;
          job_s    <= gnt_id ? bus.req1_s    : bus.req0_s;
          job_d    <= gnt_id ? bus.req1_d    : bus.req0_d;
          job_mode <= gnt_id ? bus.req1_mode : bus.req0_mode;
          job_id   <= gnt_id;
          rr_last  <= gnt_id;
        end
        SEND_D: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CW'(1);
          // a result arriving on the final timeout cycle still counts as success
          if (bus.eng_valid) begin
            res <= bus.eng_result;
            err <= 1'b0;
          end else if (timeout) begin
            res <= '0;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bitmap = '0;
    case (state)
      SEND_P:       bitmap = job_p;
      SEND_S:       bitmap = job_s;
      SEND_D, WAIT: bitmap = job_d;
      default:      bitmap = '0;
    endcase
  end

  assign bus.req0_ready  = (state == IDLE) && !arst && bus.req0_valid && !gnt_id;
  assign bus.req1_ready  = (state == IDLE) && !arst && bus.req1_valid && gnt_id;
  assign bus.eng_start   = (state == SEND_P);
  assign bus.eng_bitmap  = bitmap;
  assign bus.eng_mode    = (state == IDLE || state == RESP) ? 8'h00 : job_mode;
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_id     = (state == RESP) && job_id;
  assign bus.resp_result = (state == RESP) ? res : '0;
  assign bus.resp_err    = (state == RESP) && err;

endmodule

// File: tb/tb_rop3_scheduler.sv
// Directed bench for rop3_scheduler: a small ROP3 engine model answers each
// job after a chosen number of WAIT cycles; each scenario checks its own results.
module tb_rop3_scheduler;
  localparam int N = 8;

  logic clk = 1'b0;
  logic arst;
  int   tests = 0;
  int   fails = 0;

  rop3_scheduler_if #(.N(N)) bus();
  rop3_scheduler #(.N(N), .TIMEOUT(16), .CW(5)) dut (.clk(clk), .arst(arst), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       g0, g1;
    logic [7:0] bp, bs, bd, md, wd, wm;
    logic [2:0] st;
    int         ncyc;
    logic       rid;
    logic [7:0] rres;
    logic       rerr;
    bit         stable, rdy_seen;
    logic       after_rv, after_rdy1;
  } obs_t;

  function automatic logic [7:0] rop3(input logic [7:0] p, s, d, m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = m[{p[i], s[i], d[i]}];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [7:0] p, s, d, m);
    bus.req0_p = p; bus.req0_s = s; bus.req0_d = d; bus.req0_mode = m;
  endtask

  task automatic set_req1(input logic [7:0] p, s, d, m);
    bus.req1_p = p; bus.req1_s = s; bus.req1_d = d; bus.req1_mode = m;
  endtask

  // Runs one job from IDLE through the RESP handshake and records what was seen.
  // Cycle numbering: the accept edge is edge 0, so SEND_P is cycle 1.
  task automatic job(input bit v0, v1, keep, input int lat, input bit ovr,
                     input logic [7:0] ores, input bit stray, input int hold,
                     input bit bp1, output obs_t o);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    #1;
    o.g0 = bus.req0_ready;
    o.g1 = bus.req1_ready;
    step();
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    o.bp = bus.eng_bitmap; o.st[0] = bus.eng_start; o.md = bus.eng_mode;
    step();
    o.bs = bus.eng_bitmap; o.st[1] = bus.eng_start;
    if (stray) begin
      bus.eng_valid  = 1'b1;
      bus.eng_result = 8'h11;
    end
    step();
    bus.eng_valid = 1'b0;
    o.bd = bus.eng_bitmap; o.st[2] = bus.eng_start;
    step();
    o.wd = bus.eng_bitmap; o.wm = bus.eng_mode;
    o.ncyc = -1;
    for (int c = 4; c < 40; c++) begin
      if (bus.resp_valid) begin
        o.ncyc = c;
        break;
      end
      if (c - 3 == lat) begin
        bus.eng_valid  = 1'b1;
        bus.eng_result = ovr ? ores : rop3(o.bp, o.bs, o.bd, o.md);
      end
      step();
      bus.eng_valid = 1'b0;
    end
    o.rid = bus.resp_id; o.rres = bus.resp_result; o.rerr = bus.resp_err;
    o.stable = 1'b1;
    o.rdy_seen = 1'b0;
    if (bp1) bus.req1_valid = 1'b1;
    #1;
    if (bus.req0_ready || bus.req1_ready) o.rdy_seen = 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== o.rid ||
          bus.resp_result !== o.rres || bus.resp_err !== o.rerr) o.stable = 1'b0;
      if (bus.req0_ready || bus.req1_ready) o.rdy_seen = 1'b1;
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    #1;
    o.after_rv   = bus.resp_valid;
    o.after_rdy1 = bus.req1_ready;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    tests++; if ({bus.req0_ready, bus.req1_ready, bus.eng_start, bus.eng_bitmap, bus.eng_mode,
                  bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_err} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero, ready=%b%b start=%b bitmap=%h mode=%h rv=%b expected all 0",
                        bus.req0_ready, bus.req1_ready, bus.eng_start, bus.eng_bitmap, bus.eng_mode, bus.resp_valid);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    arst = 1'b0;
    step();
    tests++; if (bus.resp_valid !== 1'b0 || bus.eng_start !== 1'b0) begin
      fails++; $display("FAIL reset_release_idle: rv=%b start=%b expected 0 0", bus.resp_valid, bus.eng_start);
    end
  endtask

  task automatic test_single();
    obs_t o;
    set_req0(8'hF0, 8'hCC, 8'hAA, 8'hCC);
    job(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, o);
    tests++; if ({o.g0, o.g1} !== 2'b10) begin fails++; $display("FAIL single_grant: got %b expected 10", {o.g0, o.g1}); end
    tests++; if ({o.bp, o.bs, o.bd} !== 24'hF0CCAA) begin fails++; $display("FAIL single_beats: got %h expected f0ccaa", {o.bp, o.bs, o.bd}); end
    tests++; if (o.st !== 3'b001) begin fails++; $display("FAIL single_start: got %b expected 001", o.st); end
    tests++; if ({o.md, o.wm} !== 16'hCCCC) begin fails++; $display("FAIL single_mode: got %h expected cccc", {o.md, o.wm}); end
    tests++; if (o.wd !== 8'hAA) begin fails++; $display("FAIL single_wait_bitmap: got %h expected aa", o.wd); end
    tests++; if (o.ncyc !== 5) begin fails++; $display("FAIL single_latency: got %0d expected 5", o.ncyc); end
    tests++; if ({o.rid, o.rres, o.rerr} !== {1'b0, 8'hCC, 1'b0}) begin
      fails++; $display("FAIL single_resp: got id=%b res=%h err=%b expected 0 cc 0", o.rid, o.rres, o.rerr);
    end
    tests++; if (o.after_rv !== 1'b0) begin fails++; $display("FAIL single_resp_drop: got %b expected 0", o.after_rv); end
    tests++; if ({bus.eng_mode, bus.eng_bitmap} !== 16'h0000) begin
      fails++; $display("FAIL single_idle_eng: got %h expected 0000", {bus.eng_mode, bus.eng_bitmap});
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    set_req0(8'h12, 8'h34, 8'h56, 8'hF0);
    set_req1(8'h9A, 8'hBC, 8'hDE, 8'hCC);
    job(1, 0, 0, 3, 0, 8'h00, 0, 10, 1, o);
    tests++; if (o.ncyc !== 7) begin fails++; $display("FAIL bp_latency: got %0d expected 7", o.ncyc); end
    tests++; if (o.rres !== 8'h12) begin fails++; $display("FAIL bp_result: got %h expected 12", o.rres); end
    tests++; if (o.stable !== 1'b1) begin fails++; $display("FAIL bp_stable: got %b expected 1", o.stable); end
    tests++; if (o.rdy_seen !== 1'b0) begin fails++; $display("FAIL bp_no_ready: got %b expected 0", o.rdy_seen); end
    tests++; if (o.after_rdy1 !== 1'b1) begin fails++; $display("FAIL bp_next_ready: got %b expected 1", o.after_rdy1); end
    job(0, 1, 0, 1, 0, 8'h00, 0, 0, 0, o);
    tests++; if ({o.g0, o.g1} !== 2'b01) begin fails++; $display("FAIL bp_req1_grant: got %b expected 01", {o.g0, o.g1}); end
    tests++; if ({o.rid, o.rres, o.rerr} !== {1'b1, 8'hBC, 1'b0}) begin
      fails++; $display("FAIL bp_req1_resp: got id=%b res=%h err=%b expected 1 bc 0", o.rid, o.rres, o.rerr);
    end
  endtask

  task automatic test_round_robin();
    obs_t o;
    logic [7:0] exp_r;
    set_req0(8'h3C, 8'h0F, 8'h55, 8'hF0);
    set_req1(8'h81, 8'h42, 8'h24, 8'hAA);
    for (int k = 0; k < 4; k++) begin
      job(1, 1, 1, 1 + k, 0, 8'h00, 0, 0, 0, o);
      exp_r = (k % 2 == 1) ? 8'h24 : 8'h3C;
      tests++; if ({o.g0, o.g1} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin
        fails++; $display("FAIL rr_grant_%0d: got %b expected %b", k, {o.g0, o.g1}, (k % 2 == 1) ? 2'b01 : 2'b10);
      end
      tests++; if ({o.rid, o.rres} !== {(k % 2 == 1), exp_r}) begin
        fails++; $display("FAIL rr_resp_%0d: got id=%b res=%h expected %0d %h", k, o.rid, o.rres, k % 2, exp_r);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_timeout();
    obs_t o;
    set_req0(8'h77, 8'h88, 8'h99, 8'hFF);
    job(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, o);
    tests++; if (o.ncyc !== 20) begin fails++; $display("FAIL to_latency: got %0d expected 20", o.ncyc); end
    tests++; if ({o.rid, o.rres, o.rerr} !== {1'b0, 8'h00, 1'b1}) begin
      fails++; $display("FAIL to_resp: got id=%b res=%h err=%b expected 0 00 1", o.rid, o.rres, o.rerr);
    end
    set_req1(8'h01, 8'h02, 8'h04, 8'h96);
    job(0, 1, 0, 2, 0, 8'h00, 0, 0, 0, o);
    tests++; if ({o.g0, o.g1} !== 2'b01) begin fails++; $display("FAIL to_next_grant: got %b expected 01", {o.g0, o.g1}); end
    tests++; if (o.ncyc !== 6) begin fails++; $display("FAIL to_next_latency: got %0d expected 6", o.ncyc); end
    tests++; if ({o.rres, o.rerr} !== {8'h07, 1'b0}) begin
      fails++; $display("FAIL to_next_resp: got res=%h err=%b expected 07 0", o.rres, o.rerr);
    end
  endtask

  task automatic test_race();
    obs_t o;
    set_req0(8'hF0, 8'hCC, 8'hAA, 8'hCC);
    job(1, 0, 0, 16, 1, 8'h66, 1, 0, 0, o);
    tests++; if (o.ncyc !== 20) begin fails++; $display("FAIL race_latency: got %0d expected 20", o.ncyc); end
    tests++; if ({o.rres, o.rerr} !== {8'h66, 1'b0}) begin
      fails++; $display("FAIL race_resp: got res=%h err=%b expected 66 0", o.rres, o.rerr);
    end
    tests++; if (o.bd !== 8'hAA) begin fails++; $display("FAIL race_stray_beat: got %h expected aa", o.bd); end
  endtask

  task automatic test_reset_midjob();
    obs_t o;
    set_req0(8'hAB, 8'hCD, 8'hEF, 8'h5A);
    set_req1(8'h10, 8'h20, 8'h30, 8'hCC);
    bus.req0_valid = 1'b1;
    #1;
    step();
    bus.req0_valid = 1'b0;
    step();
    tests++; if (bus.eng_bitmap !== 8'hCD) begin fails++; $display("FAIL mid_send_s: got %h expected cd", bus.eng_bitmap); end
    arst = 1'b1;
    #1;
    tests++; if ({bus.eng_start, bus.eng_bitmap, bus.eng_mode, bus.resp_valid,
                  bus.resp_result, bus.resp_err} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: got bitmap=%h mode=%h expected 00 00", bus.eng_bitmap, bus.eng_mode);
    end
    bus.eng_valid  = 1'b1;
    bus.eng_result = 8'h55;
    step();
    arst = 1'b0;
    step();
    step();
    bus.eng_valid = 1'b0;
    tests++; if ({bus.resp_valid, bus.eng_start, bus.eng_mode} !== 10'b0) begin
      fails++; $display("FAIL mid_no_resp: got rv=%b start=%b mode=%h expected 0 0 00", bus.resp_valid, bus.eng_start, bus.eng_mode);
    end
    job(1, 1, 0, 1, 0, 8'h00, 0, 0, 0, o);
    tests++; if ({o.g0, o.g1} !== 2'b10) begin fails++; $display("FAIL mid_first_grant: got %b expected 10", {o.g0, o.g1}); end
    tests++; if ({o.rid, o.rres, o.rerr} !== {1'b0, 8'h44, 1'b0}) begin
      fails++; $display("FAIL mid_resp: got id=%b res=%h err=%b expected 0 44 0", o.rid, o.rres, o.rerr);
    end
  endtask

  initial begin
    arst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    set_req0(8'h00, 8'h00, 8'h00, 8'h00);
    set_req1(8'h00, 8'h00, 8'h00, 8'h00);
    bus.eng_valid = 1'b0; bus.eng_result = 8'h00; bus.resp_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_timeout();
    test_race();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
